// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Two-port arbiter sharing a single-ported, synchronous-read
//               data memory between the datapath (port 0, fixed priority)
//               and a debug/loader master (port 1, starvation-bounded).
//               Read data is returned with a per-port valid strobe one
//               cycle after the grant.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int AW       = 13,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_wen,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_wen,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          p1_forced,
    output logic [15:0]   conflict_cnt
);

    localparam logic [3:0]  C_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    // Consecutive cycles port 1 has been requesting without a grant.
    logic [3:0]  wait_cnt_q;
    logic [3:0]  wait_cnt_d;
    // One-hot owner of the read issued last cycle (bit N = port N).
    logic [1:0]  rd_owner_q;
    logic [1:0]  rd_owner_d;
    // Saturating count of cycles with both ports requesting.
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;

    logic        w_force;
    logic        w_conflict;

    // Starvation override: port 1 has waited its full budget.
    assign w_force    = p1_req && (wait_cnt_q == C_MAX_WAIT);
    assign w_conflict = p0_req && p1_req;

    // Grant decision; both grants are held low throughout reset.
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p1_forced = 1'b0;
        if (!rst) begin
            if (w_force) begin
                p1_gnt    = 1'b1;
                p1_forced = 1'b1;
            end else if (p0_req) begin
                p0_gnt    = 1'b1;
            end else if (p1_req) begin
                p1_gnt    = 1'b1;
            end
        end
    end

    // Memory pin mux: granted port drives the memory, idle drives zeros.
    always_comb begin
        mem_en    = p0_gnt | p1_gnt;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_wen   = p0_wen;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_wen   = p1_wen;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    // Next-state for the wait counter, read owner and conflict counter.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!p1_req || p1_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != C_MAX_WAIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_owner_d = {p1_gnt & ~p1_wen, p0_gnt & ~p0_wen};

        conflict_cnt_d = conflict_cnt_q;
        if (w_conflict && (conflict_cnt_q != C_CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // State registers; reset also kills any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q     <= 4'd0;
            rd_owner_q     <= 2'b00;
            conflict_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            rd_owner_q     <= rd_owner_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Read return: data is only passed through to the port that owns it.
    always_comb begin
        p0_rvalid = rd_owner_q[0];
        p1_rvalid = rd_owner_q[1];
        p0_rdata  = rd_owner_q[0] ? mem_rdata : '0;
        p1_rdata  = rd_owner_q[1] ? mem_rdata : '0;
    end

    assign conflict_cnt = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter with a
//               behavioural synchronous-read data memory attached.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_wen, p1_req, p1_wen;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          p1_forced;
    logic [15:0]   conflict_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_conf = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req       (p0_req),
        .p0_wen       (p0_wen),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (p1_req),
        .p1_wen       (p1_wen),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .p1_forced    (p1_forced),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural single-ported synchronous-read memory.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            else         mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: count a conflict if both request across the edge, then
    // land on the falling edge where outputs are sampled.
    task automatic tick();
        if (p0_req && p1_req && exp_conf < 16'hFFFF) exp_conf++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[13'h0010] = 32'hDEADBEEF;
        mem_rdata = '0;
        rst = 1'b1;
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b1; p1_wen = 1'b0; p1_addr = '0; p1_wdata = '0;

        // ---- Reset with both requesting
        tick(); tick();
        exp_conf = 0;
        chk("rst_p0_gnt",    32'(p0_gnt), 0);
        chk("rst_p1_gnt",    32'(p1_gnt), 0);
        chk("rst_mem_en",    32'(mem_en), 0);
        chk("rst_mem_addr",  32'(mem_addr), 0);
        chk("rst_conflict",  32'(conflict_cnt), 0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
        chk("rst_p0_rdata",  p0_rdata, 0);
        chk("rst_forced",    32'(p1_forced), 0);
        rst = 1'b0;
        #1;
        chk("rel_p0_gnt", 32'(p0_gnt), 1);
        chk("rel_p1_gnt", 32'(p1_gnt), 0);
        chk("rel_mem_en", 32'(mem_en), 1);
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        chk("rel_conflict", 32'(conflict_cnt), 1);
        chk("rel_p0_rvalid", 32'(p0_rvalid), 1);
        tick();

        // ---- p0 read alone of 0x0010
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 13'h0010;
        #1;
        chk("rd_p0_gnt",   32'(p0_gnt), 1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0010);
        chk("rd_mem_wen",  32'(mem_wen), 0);
        chk("rd_p1_rv_n",  32'(p1_rvalid), 0);
        tick();
        p0_req = 1'b0;
        #1;
        chk("rd_p0_rvalid", 32'(p0_rvalid), 1);
        chk("rd_p0_rdata",  p0_rdata, 32'hDEADBEEF);
        chk("rd_p1_rvalid", 32'(p1_rvalid), 0);
        chk("rd_p1_rdata",  p1_rdata, 0);
        chk("rd_idle_en",   32'(mem_en), 0);
        tick();
        chk("rd_rvalid_off", 32'(p0_rvalid), 0);
        chk("rd_rdata_off",  p0_rdata, 0);

        // ---- p1 write 0x1FFF then p0 read of the same address
        p1_req = 1'b1; p1_wen = 1'b1; p1_addr = 13'h1FFF; p1_wdata = 32'h12345678;
        #1;
        chk("wr_p1_gnt",    32'(p1_gnt), 1);
        chk("wr_forced",    32'(p1_forced), 0);
        chk("wr_mem_wen",   32'(mem_wen), 1);
        chk("wr_mem_addr",  32'(mem_addr), 32'h1FFF);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        p1_req = 1'b0;
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 13'h1FFF;
        #1;
        chk("wr_no_rvalid", 32'(p1_rvalid), 0);
        chk("wr_p0_gnt",    32'(p0_gnt), 1);
        tick();
        p0_req = 1'b0;
        #1;
        chk("raw_p0_rvalid", 32'(p0_rvalid), 1);
        chk("raw_p0_rdata",  p0_rdata, 32'h12345678);
        tick();

        // ---- Back-to-back: p0 read, then p1 read the next cycle
        p0_req = 1'b1; p0_addr = 13'h0010;
        tick();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 13'h1FFF;
        #1;
        chk("b2b_p0_rvalid", 32'(p0_rvalid), 1);
        chk("b2b_p0_rdata",  p0_rdata, 32'hDEADBEEF);
        chk("b2b_p1_gnt",    32'(p1_gnt), 1);
        tick();
        p1_req = 1'b0;
        #1;
        chk("b2b_p1_rvalid", 32'(p1_rvalid), 1);
        chk("b2b_p1_rdata",  p1_rdata, 32'h12345678);
        chk("b2b_p0_rv_off", 32'(p0_rvalid), 0);
        chk("b2b_p0_rd_off", p0_rdata, 0);
        tick();

        // ---- Starvation: both request continuously, p1 wins every 5th cycle
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 13'h0010;
        p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 13'h1FFF;
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk($sformatf("stv_p0_gnt_%0d", k), 32'(p0_gnt), (k % 5 == 0) ? 0 : 1);
            chk($sformatf("stv_p1_gnt_%0d", k), 32'(p1_gnt), (k % 5 == 0) ? 1 : 0);
            chk($sformatf("stv_forced_%0d", k), 32'(p1_forced), (k % 5 == 0) ? 1 : 0);
            chk($sformatf("stv_conf_%0d", k), 32'(conflict_cnt), 32'(exp_conf));
            tick();
        end

        // ---- p1 drops req mid-wait: its counter restarts from zero
        tick(); tick();
        p1_req = 1'b0;
        tick();
        p1_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("drop_p1_gnt_%0d", k), 32'(p1_gnt), (k == 5) ? 1 : 0);
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        chk("stv_conf_end", 32'(conflict_cnt), 32'(exp_conf));

        // ---- Reset during read return
        p0_req = 1'b1; p1_req = 1'b1;
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        chk("rr_p0_rvalid_pre", 32'(p0_rvalid), 1);
        chk("rr_wait_pre",      32'(dut.wait_cnt_q), 1);
        rst = 1'b1;
        p0_req = 1'b1;
        #1;
        chk("rr_p0_rvalid", 32'(p0_rvalid), 0);
        chk("rr_p0_rdata",  p0_rdata, 0);
        chk("rr_wait",      32'(dut.wait_cnt_q), 0);
        chk("rr_p0_gnt",    32'(p0_gnt), 0);
        chk("rr_mem_en",    32'(mem_en), 0);
        tick();
        p0_req = 1'b0;
        rst = 1'b0;
        exp_conf = 0;
        tick();

        // ---- Conflict counter saturation
        p0_req = 1'b1; p1_req = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", 32'(conflict_cnt), 32'h0000FFFE);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("sat_ffff_%0d", k), 32'(conflict_cnt), 32'h0000FFFF);
        end
        chk("sat_model", 32'(conflict_cnt), 32'(exp_conf));
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
